// File: rtl/icache_tgen_pkg.sv
// ---------------------------------------------------------------------------
// icache_tgen_pkg
// Shared types and helpers for the multi-port icache fetch traffic generator.
//   mode_e       : address stream mode (random, sequential, loop-8, mixed)
//   tgen_state_e : per-port sequencing FSM states
//   LFSR_TAPS    : Galois feedback taps of the 32-bit address LFSR
//   lfsr_step()  : one Galois LFSR advance
//   golden_line(): closed-form expected line for an address, lane k = A + 4*k,
//                  built at the widest supported line and truncated by callers
// ---------------------------------------------------------------------------
package icache_tgen_pkg;

   typedef enum logic [1:0] {
      MODE_RANDOM = 2'd0,
      MODE_SEQ    = 2'd1,
      MODE_LOOP8  = 2'd2,
      MODE_MIXED  = 2'd3
   } mode_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_DELAY = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } tgen_state_e;

   localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
   localparam int          GOLDEN_MAX_W = 512;

   // Right-shifting Galois form: the bit shifted out selects the tap XOR.
   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
   endfunction

   function automatic logic [GOLDEN_MAX_W-1:0] golden_line(input logic [31:0] addr);
      logic [GOLDEN_MAX_W-1:0] line;
      line = '0;
      for (int k = 0; k < GOLDEN_MAX_W/32; k++) begin
         line[k*32 +: 32] = addr + 32'(4*k);
      end
      return line;
   endfunction

endpackage

// File: rtl/icache_tgen_chan.sv
// ---------------------------------------------------------------------------
// icache_tgen_chan
// One fetch port of the traffic generator: sequencing FSM, address LFSR,
// expected-address FIFO and response checker.
//   clk, rst_n          : clock, asynchronous active-low reset
//   enable_i            : run enable
//   mode_i, delay_max_i : stream mode and gap mask, captured while idle
//   req_o, addr_o       : fetch request and registered address
//   gnt_i               : grant, accepted in the same cycle as req_o
//   rvalid_i, rdata_i   : returned line, checked against golden_line()
//   err_cnt_o           : saturating mismatch/spurious-response counter
//   done_o              : port has issued and drained all transactions
// ---------------------------------------------------------------------------
module icache_tgen_chan
   import icache_tgen_pkg::*;
#(
   parameter int          AW              = 32,
   parameter int          DW              = 128,
   parameter int          N_TRANS         = 1024,
   parameter int          MAX_OUTSTANDING = 2,
   parameter logic [31:0] ADDR_MASK       = 32'h0000_0FF0,
   parameter logic [31:0] PORT_SEED       = 32'hACE1_0001
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          enable_i,
   input  logic [1:0]    mode_i,
   input  logic [3:0]    delay_max_i,
   output logic          req_o,
   output logic [AW-1:0] addr_o,
   input  logic          gnt_i,
   input  logic          rvalid_i,
   input  logic [DW-1:0] rdata_i,
   output logic [15:0]   err_cnt_o,
   output logic          done_o
);

   localparam int          CW         = $clog2(N_TRANS + 1);
   localparam logic [CW-1:0] N_TRANS_C = CW'(N_TRANS);
   localparam logic [2:0]  MAX_OUT    = 3'(MAX_OUTSTANDING);
   localparam logic [31:0] LINE_BYTES = 32'(DW/8);

   tgen_state_e   r_state, w_stateNext;
   mode_e         r_mode, w_modeEff;
   logic [31:0]   r_lfsr, r_base;
   logic [AW-1:0] r_addr;
   logic [3:0]    r_delayMax, r_delay;
   logic [CW-1:0] r_issued;
   logic [2:0]    r_outst;
   logic [1:0]    r_wrPtr, r_rdPtr;
   logic [15:0]   r_errCnt;
   logic [AW-1:0] r_fifo [4];

   logic          w_req, w_accept, w_pop, w_spurious, w_mismatch, w_firstLoad;
   logic [CW-1:0] w_issuedNext;
   logic [31:0]   w_lfsrNext, w_addrFirst, w_addrNext;
   logic [3:0]    w_gap;
   logic [DW-1:0] w_golden;

   // Address for stream index idx given the LFSR value for that index, the
   // sequential candidate (previous + one line) and the loop-8 base.
   function automatic logic [31:0] genAddr(input mode_e m, input logic [31:0] lv,
                                           input logic [31:0] seq, input logic [31:0] base,
                                           input logic [2:0] idx);
      logic [31:0] a;
      case (m)
         MODE_RANDOM: a = lv;
         MODE_SEQ:    a = seq;
         MODE_LOOP8:  a = base + 32'(idx) * LINE_BYTES;
         default:     a = lv[31] ? lv : seq;
      endcase
      return a & ADDR_MASK;
   endfunction

   // While idle the live mode input is what the first address must follow,
   // since it is captured into r_mode on that same edge.
   assign w_modeEff    = (r_state == ST_IDLE) ? mode_e'(mode_i) : r_mode;
   assign w_issuedNext = r_issued + CW'(1);
   assign w_lfsrNext   = lfsr_step(r_lfsr);
   assign w_gap        = r_lfsr[3:0] & r_delayMax;
   assign w_firstLoad  = (r_state == ST_IDLE) && enable_i && (r_issued == '0);
   assign w_addrFirst  = genAddr(w_modeEff, r_lfsr, 32'h0, r_lfsr & ADDR_MASK, 3'd0);
   assign w_addrNext   = genAddr(r_mode, w_lfsrNext, 32'(r_addr) + LINE_BYTES, r_base,
                                 3'(w_issuedNext));
   assign w_accept     = w_req & gnt_i;
   assign w_pop        = rvalid_i && (r_outst != 3'd0);
   assign w_spurious   = rvalid_i && (r_outst == 3'd0);
   assign w_golden     = DW'(golden_line(32'(r_fifo[r_rdPtr])));
   assign w_mismatch   = (rdata_i != w_golden);

   // Next-state and request decode. A full port may still request when a
   // response frees a slot this cycle; req never drops without a grant
   // because outstanding can only fall while waiting.
   always_comb begin
      w_stateNext = r_state;
      w_req       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (enable_i) w_stateNext = ST_ISSUE;
         end
         ST_ISSUE: begin
            w_req = (r_outst < MAX_OUT) || ((r_outst == MAX_OUT) && rvalid_i);
            if (w_req && gnt_i) begin
               if (w_issuedNext == N_TRANS_C) w_stateNext = ST_DRAIN;
               else if (!enable_i)            w_stateNext = ST_IDLE;
               else if (w_gap != 4'd0)        w_stateNext = ST_DELAY;
            end else if (!w_req && !enable_i) begin
               w_stateNext = ST_IDLE;
            end
         end
         ST_DELAY: begin
            if (!enable_i)               w_stateNext = ST_IDLE;
            else if (r_delay <= 4'd1)    w_stateNext = ST_ISSUE;
         end
         ST_DRAIN: begin
            if (r_outst == 3'd0) w_stateNext = ST_DONE;
         end
         ST_DONE:  w_stateNext = ST_DONE;
         default:  w_stateNext = ST_IDLE;
      endcase
   end

   // State, stream generator, counters and checker. The LFSR and address
   // only move on an accepted request so a stalled request stays put.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_mode     <= MODE_RANDOM;
         r_lfsr     <= PORT_SEED;
         r_base     <= 32'h0;
         r_addr     <= '0;
         r_delayMax <= 4'd0;
         r_delay    <= 4'd0;
         r_issued   <= '0;
         r_outst    <= 3'd0;
         r_wrPtr    <= 2'd0;
         r_rdPtr    <= 2'd0;
         r_errCnt   <= 16'd0;
      end else begin
         r_state <= w_stateNext;
         if (r_state == ST_IDLE) begin
            r_mode     <= mode_e'(mode_i);
            r_delayMax <= delay_max_i;
         end
         if (w_firstLoad) begin
            r_addr <= AW'(w_addrFirst);
            r_base <= r_lfsr & ADDR_MASK;
         end
         if (w_accept) begin
            r_lfsr   <= w_lfsrNext;
            r_issued <= w_issuedNext;
            r_addr   <= AW'(w_addrNext);
            r_wrPtr  <= r_wrPtr + 2'd1;
         end
         if (w_pop) r_rdPtr <= r_rdPtr + 2'd1;
         if (w_accept && !w_pop)      r_outst <= r_outst + 3'd1;
         else if (!w_accept && w_pop) r_outst <= r_outst - 3'd1;
         if ((r_state == ST_ISSUE) && (w_stateNext == ST_DELAY)) r_delay <= w_gap;
         else if (r_state == ST_DELAY)                           r_delay <= r_delay - 4'd1;
         if (((w_pop && w_mismatch) || w_spurious) && (r_errCnt != 16'hFFFF))
            r_errCnt <= r_errCnt + 16'd1;
      end
   end

   // Expected-address storage; validity is tracked by the pointers and the
   // outstanding count, so the array itself needs no reset.
   always_ff @(posedge clk) begin
      if (w_accept) r_fifo[r_wrPtr] <= r_addr;
   end

   assign req_o     = w_req;
   assign addr_o    = r_addr;
   assign err_cnt_o = r_errCnt;
   assign done_o    = (r_state == ST_DONE);

endmodule

// File: rtl/icache_tgen_mp.sv
// ---------------------------------------------------------------------------
// icache_tgen_mp
// Multi-port fetch traffic generator: NB_PORTS independent checked channels
// plus a registered all-done flag.
//   clk, rst_n      : clock, asynchronous active-low reset
//   fetch_enable_i  : global run enable
//   mode_i          : 0 random, 1 sequential, 2 loop-8, 3 mixed
//   delay_max_i     : mask on the random inter-request gap
//   fetch_req_o     : per-port request
//   fetch_addr_o    : per-port address, port p at [p*ADDR_W +: ADDR_W]
//   fetch_gnt_i     : per-port grant
//   fetch_rvalid_i  : per-port response valid
//   fetch_rdata_i   : per-port response line
//   err_cnt_o       : per-port 16-bit saturating error count
//   eoc_o           : every port finished
// ---------------------------------------------------------------------------
module icache_tgen_mp
   import icache_tgen_pkg::*;
#(
   parameter int          NB_PORTS         = 4,
   parameter int          FETCH_ADDR_WIDTH = 32,
   parameter int          FETCH_DATA_WIDTH = 128,
   parameter int          N_TRANS          = 1024,
   parameter int          MAX_OUTSTANDING  = 2,
   parameter logic [31:0] ADDR_MASK        = 32'h0000_0FF0,
   parameter logic [31:0] SEED             = 32'hACE1_0001
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 fetch_enable_i,
   input  logic [1:0]                           mode_i,
   input  logic [3:0]                           delay_max_i,
   output logic [NB_PORTS-1:0]                  fetch_req_o,
   output logic [NB_PORTS*FETCH_ADDR_WIDTH-1:0] fetch_addr_o,
   input  logic [NB_PORTS-1:0]                  fetch_gnt_i,
   input  logic [NB_PORTS-1:0]                  fetch_rvalid_i,
   input  logic [NB_PORTS*FETCH_DATA_WIDTH-1:0] fetch_rdata_i,
   output logic [NB_PORTS*16-1:0]               err_cnt_o,
   output logic                                 eoc_o
);

   localparam int AW = FETCH_ADDR_WIDTH;
   localparam int DW = FETCH_DATA_WIDTH;

   logic [NB_PORTS-1:0] w_done;
   logic                r_eoc;

   // Each port gets its own seed so the random streams differ between cores.
   for (genvar p = 0; p < NB_PORTS; p++) begin : g_port
      icache_tgen_chan #(
         .AW              (AW),
         .DW              (DW),
         .N_TRANS         (N_TRANS),
         .MAX_OUTSTANDING (MAX_OUTSTANDING),
         .ADDR_MASK       (ADDR_MASK),
         .PORT_SEED       (SEED + 32'(p))
      ) u_chan (
         .clk         (clk),
         .rst_n       (rst_n),
         .enable_i    (fetch_enable_i),
         .mode_i      (mode_i),
         .delay_max_i (delay_max_i),
         .req_o       (fetch_req_o[p]),
         .addr_o      (fetch_addr_o[p*AW +: AW]),
         .gnt_i       (fetch_gnt_i[p]),
         .rvalid_i    (fetch_rvalid_i[p]),
         .rdata_i     (fetch_rdata_i[p*DW +: DW]),
         .err_cnt_o   (err_cnt_o[p*16 +: 16]),
         .done_o      (w_done[p])
      );
   end

   // End of campaign is registered so it is glitch-free for the host.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_eoc <= 1'b0;
      else        r_eoc <= &w_done;
   end

   assign eoc_o = r_eoc;

endmodule

// File: tb/tb_icache_tgen_mp.sv
module tb_icache_tgen_mp;

   localparam int          NB   = 2;
   localparam int          AW   = 32;
   localparam int          DW   = 128;
   localparam int          NT   = 258;
   localparam int          MAXO = 2;
   localparam logic [31:0] MASK = 32'h0000_0FF0;
   localparam logic [31:0] SEED = 32'hACE1_0001;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             fetchEnable = 1'b0;
   logic [1:0]       mode = 2'd0;
   logic [3:0]       delayMax = 4'd0;
   logic [NB-1:0]    req;
   logic [NB*AW-1:0] addr;
   logic [NB-1:0]    gnt = '0;
   logic [NB-1:0]    rvalid = '0;
   logic [NB*DW-1:0] rdata = '0;
   logic [NB*16-1:0] errCnt;
   logic             eoc;

   typedef struct {
      logic [31:0] a;
      int          due;
   } resp_t;

   int          total = 0;
   int          bad = 0;
   logic [31:0] expQ [NB][$];
   resp_t       respQ [NB][$];
   int          cycle = 0;
   int          latency = 1;
   int          gntStall = 0;
   int          stallCnt [NB];
   int          respNum [NB];
   int          accCnt [NB];
   int          benchOut [NB];
   bit          pend [NB];
   logic [31:0] pendAddr [NB];
   bit          spurious [NB];
   bit          corruptOn = 0;
   int          dropAt = 0;
   int          sameCycle = 0;
   int          newOut;

   always #5 clk = ~clk;

   icache_tgen_mp #(
      .NB_PORTS(NB), .FETCH_ADDR_WIDTH(AW), .FETCH_DATA_WIDTH(DW), .N_TRANS(NT),
      .MAX_OUTSTANDING(MAXO), .ADDR_MASK(MASK), .SEED(SEED)
   ) dut (
      .clk(clk), .rst_n(rst_n), .fetch_enable_i(fetchEnable), .mode_i(mode),
      .delay_max_i(delayMax), .fetch_req_o(req), .fetch_addr_o(addr),
      .fetch_gnt_i(gnt), .fetch_rvalid_i(rvalid), .fetch_rdata_i(rdata),
      .err_cnt_o(errCnt), .eoc_o(eoc)
   );

   function automatic logic [31:0] lfsrModel(input logic [31:0] s);
      logic [31:0] n;
      n = {1'b0, s[31:1]};
      if (s[0]) n = n ^ 32'h8020_0003;
      return n;
   endfunction

   function automatic logic [DW-1:0] lineFor(input logic [31:0] a);
      logic [DW-1:0] l;
      for (int k = 0; k < DW/32; k++) l[k*32 +: 32] = a + 32'(4*k);
      return l;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic fillExpected(input int m);
      logic [31:0] lf, prev, base, seq, a;
      for (int p = 0; p < NB; p++) begin
         lf   = SEED + 32'(p);
         base = lf & MASK;
         prev = 32'h0;
         for (int i = 0; i < NT; i++) begin
            seq = (i == 0) ? 32'h0 : ((prev + 32'h10) & MASK);
            case (m)
               0:       a = lf & MASK;
               1:       a = 32'(i * 16) & MASK;
               2:       a = (base + 32'((i % 8) * 16)) & MASK;
               default: a = lf[31] ? (lf & MASK) : seq;
            endcase
            expQ[p].push_back(a);
            prev = a;
            lf   = lfsrModel(lf);
         end
      end
   endtask

   // One clock of the memory model: drive grant/response at the falling
   // edge, then record what the DUT will see accepted on the next rise.
   task automatic stepCycle();
      resp_t         r;
      logic [DW-1:0] line;
      @(negedge clk);
      cycle++;
      for (int p = 0; p < NB; p++) begin
         gnt[p] = (gntStall == 0) || (stallCnt[p] >= gntStall);
         rvalid[p] = 1'b0;
         rdata[p*DW +: DW] = '0;
         if (respQ[p].size() > 0 && respQ[p][0].due <= cycle) begin
            r = respQ[p].pop_front();
            respNum[p]++;
            line = lineFor(r.a);
            if (corruptOn && p == 0 && respNum[p] == 3) line[71] = ~line[71];
            rvalid[p] = 1'b1;
            rdata[p*DW +: DW] = line;
         end
         if (spurious[p]) begin
            rvalid[p] = 1'b1;
            spurious[p] = 1'b0;
         end
      end
      #1;
      for (int p = 0; p < NB; p++) begin
         if (req[p]) begin
            if (gnt[p]) begin
               r.a = addr[p*AW +: AW];
               r.due = cycle + latency;
               respQ[p].push_back(r);
               stallCnt[p] = 0;
               accCnt[p]++;
            end else begin
               stallCnt[p]++;
            end
         end
      end
      if (dropAt > 0 && accCnt[0] == dropAt && req[0] && gnt[0]) begin
         fetchEnable = 1'b0;
         dropAt = 0;
      end
   endtask

   task automatic checkResetState();
      checkOutput("rstReq", 64'(req), 64'd0);
      checkOutput("rstAddr", 64'(addr), 64'd0);
      checkOutput("rstErr", 64'(errCnt), 64'd0);
      checkOutput("rstEoc", 64'(eoc), 64'd0);
   endtask

   task automatic doReset();
      @(negedge clk);
      #3;
      rst_n = 1'b0;
      fetchEnable = 1'b0;
      #1;
      checkResetState();
      for (int p = 0; p < NB; p++) begin
         expQ[p].delete();
         respQ[p].delete();
         stallCnt[p] = 0;
         respNum[p] = 0;
         accCnt[p] = 0;
         spurious[p] = 1'b0;
      end
      repeat (2) stepCycle();
      #2;
      rst_n = 1'b1;
   endtask

   task automatic applyStimulus(input int m, input logic [3:0] dmax, input int stall, input int lat);
      doReset();
      mode = 2'(m);
      delayMax = dmax;
      gntStall = stall;
      latency = lat;
      corruptOn = 0;
      sameCycle = 0;
      fillExpected(m);
      fetchEnable = 1'b1;
   endtask

   task automatic runToEoc(input string name, input int budget);
      for (int c = 0; c < budget && !eoc; c++) stepCycle();
      checkOutput({name, "_eoc"}, 64'(eoc), 64'd1);
      for (int p = 0; p < NB; p++) checkOutput({name, "_expLeft"}, 64'(expQ[p].size()), 64'd0);
   endtask

   // Scoreboard monitor: pops the expected address on every accepted
   // request and tracks outstanding traffic and request stability.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (!rst_n) begin
            for (int p = 0; p < NB; p++) begin
               benchOut[p] = 0;
               pend[p] = 1'b0;
            end
         end else begin
            for (int p = 0; p < NB; p++) begin
               if (pend[p]) begin
                  checkOutput("reqHold", 64'(req[p]), 64'd1);
                  checkOutput("addrHold", 64'(addr[p*AW +: AW]), 64'(pendAddr[p]));
               end
               newOut = benchOut[p];
               if (rvalid[p] && newOut > 0) newOut--;
               if (req[p] && gnt[p]) begin
                  if (rvalid[p] && benchOut[p] == MAXO) sameCycle++;
                  newOut++;
                  checkOutput("outstandingLimit", 64'(newOut <= MAXO), 64'd1);
                  if (expQ[p].size() == 0) checkOutput("extraReq", 64'd1, 64'd0);
                  else checkOutput("addr", 64'(addr[p*AW +: AW]), 64'(expQ[p].pop_front()));
               end
               pend[p] = req[p] && !gnt[p];
               pendAddr[p] = addr[p*AW +: AW];
               benchOut[p] = newOut;
            end
         end
      end
   end

   initial begin
      for (int p = 0; p < NB; p++) begin
         stallCnt[p] = 0; respNum[p] = 0; accCnt[p] = 0; benchOut[p] = 0;
         pend[p] = 0; pendAddr[p] = 0; spurious[p] = 0;
      end

      // Sequential stream with full wrap past 0xFF0, immediate grants.
      applyStimulus(1, 4'd0, 0, 1);
      runToEoc("seq", 5000);
      checkOutput("seqErr0", 64'(errCnt[15:0]), 64'd0);
      checkOutput("seqErr1", 64'(errCnt[31:16]), 64'd0);

      // Random stream with every grant held off for 5 cycles.
      applyStimulus(0, 4'd0, 5, 1);
      runToEoc("stall", 5000);
      checkOutput("stallErr0", 64'(errCnt[15:0]), 64'd0);

      // Loop-8 stream with slow responses: outstanding limit and
      // same-cycle grant-plus-response.
      applyStimulus(2, 4'd0, 0, 4);
      runToEoc("loop8", 5000);
      checkOutput("loop8SameCycle", 64'(sameCycle > 0), 64'd1);
      checkOutput("loop8Err0", 64'(errCnt[15:0]), 64'd0);

      // Spurious response on an idle port.
      applyStimulus(1, 4'd0, 0, 1);
      fetchEnable = 1'b0;
      spurious[1] = 1'b1;
      repeat (3) stepCycle();
      checkOutput("spurErr1", 64'(errCnt[31:16]), 64'd1);
      checkOutput("spurErr0", 64'(errCnt[15:0]), 64'd0);

      // Mixed stream with gaps, third response of port 0 corrupted.
      applyStimulus(3, 4'h3, 0, 1);
      corruptOn = 1;
      runToEoc("mixed", 8000);
      checkOutput("corruptErr0", 64'(errCnt[15:0]), 64'd1);
      checkOutput("corruptErr1", 64'(errCnt[31:16]), 64'd0);

      // Enable dropped at issued=5, resumed, then reset during drain.
      applyStimulus(0, 4'd0, 0, 6);
      dropAt = 5;
      for (int c = 0; c < 200 && accCnt[0] < 5; c++) stepCycle();
      repeat (8) stepCycle();
      checkOutput("pauseAcc", 64'(accCnt[0]), 64'd5);
      checkOutput("pauseReq", 64'(req), 64'd0);
      checkOutput("pauseAddr0", 64'(addr[AW-1:0]), 64'h800);
      checkOutput("pauseExpLeft", 64'(expQ[0].size()), 64'(NT - 5));
      fetchEnable = 1'b1;
      for (int c = 0; c < 5000 && accCnt[0] < NT; c++) stepCycle();
      repeat (2) stepCycle();
      checkOutput("drainAcc", 64'(accCnt[0]), 64'(NT));
      checkOutput("drainEoc", 64'(eoc), 64'd0);
      applyStimulus(0, 4'd0, 0, 1);
      runToEoc("restart", 5000);
      checkOutput("restartErr0", 64'(errCnt[15:0]), 64'd0);
      checkOutput("restartErr1", 64'(errCnt[31:16]), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
